ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte to the keyboard, e.g. 0xED (set LEDs) or 0xF4 (enable scanning), over the same open-collector keyclk/keyinput pair that the keyboard receiver listens on. It runs the inhibit/request-to-send sequence, shifts the frame out on device-generated clock edges, checks the device acknowledge, and reports completion or failure. It sits beside the keyboard receiver under the game top level. The top level turns each `_oe` into a pin low-drive (pin is 0 when `_oe` is 1, high-Z otherwise). The receiver must ignore the bus while `busy` is high.

---
 rtl/ps2_host_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Runs the clock-inhibit / request-to-send handshake, shifts one byte out
// (LSB first, odd parity, stop) on device-generated clock falls, checks the
// device acknowledge and reports done or err. Pins are open-collector: each
// *_oe output set to 1 means "pull that line low".
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       keyclk_in,
    input  logic       keyinput_in,
    output logic       keyclk_oe,
    output logic       keyinput_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_BITS,
        S_PARITY,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    // Pin synchronizers; reset to 1 (idle bus) so reset release never looks like a fall
    logic            r_clk_s1;
    logic            r_clk_s2;
    logic            r_clk_s3;
    logic            r_dat_s1;
    logic            r_dat_s2;
    logic            w_fall;

    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic            r_parity;
    logic            w_parity_next;
    logic [2:0]      r_bit_cnt;
    logic [2:0]      w_bit_cnt_next;
    logic            r_ack_bit;
    logic            w_ack_bit_next;
    logic [IW-1:0]   r_inh_cnt;
    logic [IW-1:0]   w_inh_cnt_next;
    logic [TW-1:0]   r_tmo_cnt;
    logic [TW-1:0]   w_tmo_cnt_next;
    logic            w_in_frame;

    logic            r_keyclk_oe;
    logic            r_keyinput_oe;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            r_tx_ready;
    logic            w_keyclk_oe_next;
    logic            w_keyinput_oe_next;

    assign w_fall      = r_clk_s3 & ~r_clk_s2;
    assign w_in_frame  = (r_state == S_START) || (r_state == S_BITS) ||
                         (r_state == S_PARITY) || (r_state == S_STOP) ||
                         (r_state == S_ACK) || (r_state == S_WAIT_IDLE);

    assign keyclk_oe   = r_keyclk_oe;
    assign keyinput_oe = r_keyinput_oe;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign tx_ready    = r_tx_ready;

    // Two-stage synchronizers plus one extra clock stage for fall detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= keyclk_in;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= keyinput_in;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Next-state, datapath and output decode; outputs follow the next state so they are registered
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_bit_cnt_next = r_bit_cnt;
        w_ack_bit_next = r_ack_bit;
        w_inh_cnt_next = r_inh_cnt;
        w_tmo_cnt_next = r_tmo_cnt;

        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_state_next   = S_INHIBIT;
                    w_shift_next   = tx_data;
                    w_parity_next  = ~^tx_data;
                    w_inh_cnt_next = '0;
                end
            end
            S_INHIBIT: begin
                if (r_inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                    w_state_next   = S_START;
                    w_tmo_cnt_next = '0;
                end else begin
                    w_inh_cnt_next = r_inh_cnt + IW'(1);
                end
            end
            S_START: begin
                if (w_fall) begin
                    w_state_next   = S_BITS;
                    w_bit_cnt_next = 3'd0;
                end
            end
            S_BITS: begin
                if (w_fall) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_PARITY;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                // The 11th device fall carries the acknowledge: capture the data line on it
                if (w_fall) begin
                    w_state_next   = S_ACK;
                    w_ack_bit_next = r_dat_s2;
                end
            end
            S_ACK: begin
                w_state_next = r_ack_bit ? S_ERR : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (r_clk_s2 && r_dat_s2) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            S_ERR: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Frame watchdog; its terminal count overrides any transition taken above
        if (w_in_frame) begin
            w_tmo_cnt_next = r_tmo_cnt + TW'(1);
            if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                w_state_next = S_ERR;
            end
        end

        w_keyclk_oe_next = (w_state_next == S_INHIBIT);
        case (w_state_next)
            S_START:  w_keyinput_oe_next = 1'b1;
            S_BITS:   w_keyinput_oe_next = ~w_shift_next[0];
            S_PARITY: w_keyinput_oe_next = ~w_parity_next;
            default:  w_keyinput_oe_next = 1'b0;
        endcase
    end

    // State, datapath and registered outputs; reset releases both lines at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_shift       <= 8'h00;
            r_parity      <= 1'b0;
            r_bit_cnt     <= 3'd0;
            r_ack_bit     <= 1'b1;
            r_inh_cnt     <= '0;
            r_tmo_cnt     <= '0;
            r_keyclk_oe   <= 1'b0;
            r_keyinput_oe <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_tx_ready    <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_shift       <= w_shift_next;
            r_parity      <= w_parity_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_ack_bit     <= w_ack_bit_next;
            r_inh_cnt     <= w_inh_cnt_next;
            r_tmo_cnt     <= w_tmo_cnt_next;
            r_keyclk_oe   <= w_keyclk_oe_next;
            r_keyinput_oe <= w_keyinput_oe_next;
            r_busy        <= (w_state_next != S_IDLE);
            r_done        <= (w_state_next == S_DONE);
            r_err         <= (w_state_next == S_ERR);
            r_tx_ready    <= (w_state_next == S_IDLE);
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device model.
// The device clock is scaled down (half period H clk cycles) to keep runs short.
module tb_ps2_host_tx;

    localparam int INH = 5000;
    localparam int TMO = 2000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       keyclk_oe;
    logic       keyinput_oe;
    logic       busy;
    logic       done;
    logic       err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       keyclk_pin;
    logic       keyinput_pin;

    // Open-collector bus: either side pulling low wins
    assign keyclk_pin   = ~(keyclk_oe | dev_clk_low);
    assign keyinput_pin = ~(keyinput_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .keyclk_in   (keyclk_pin),
        .keyinput_in (keyinput_pin),
        .keyclk_oe   (keyclk_oe),
        .keyinput_oe (keyinput_oe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int inh_run  = 0;
    int inh_last = 0;

    // Pulse counters and keyclk_oe run-length monitor
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (keyclk_oe) begin
            inh_run++;
        end else if (inh_run != 0) begin
            inh_last = inh_run;
            inh_run  = 0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept a byte, optionally poke a second request while busy, wait for START
    task automatic start_tx(input logic [7:0] b, input bit inject, output bit ok);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_val("accept_keyclk_oe", keyclk_oe, 1);
        check_val("accept_busy", busy, 1);
        check_val("accept_tx_ready", tx_ready, 0);
        if (inject) begin
            repeat (50) @(negedge clk);
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = 8'h00;
        end
        ok = 1'b0;
        for (int i = 0; i < INH + 20; i++) begin
            if (keyinput_oe) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("start_seen", ok, 1);
        check_val("start_keyclk_released", keyclk_oe, 0);
        @(negedge clk);
        check_val("inhibit_len", inh_last, INH);
    endtask

    // Device side: 11 clock pulses, bits read at rising edges, ack driven before the 11th fall
    task automatic dev_frame(input bit do_ack, input int abort_at, output logic [10:0] cap);
        cap = '0;
        repeat (H) @(negedge clk);
        cap[0] = keyinput_pin;
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (k == abort_at) return;
            dev_clk_low = 1'b0;
            if (k <= 10) cap[k] = keyinput_pin;
            if (k == 10 && do_ack) dev_data_low = 1'b1;
            repeat (H) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    // Full successful transfer with frame and handshake checks
    task automatic send_ok(input logic [7:0] b, input logic exp_par, input bit inject);
        bit          ok;
        bit          seen;
        int          d0;
        int          e0;
        logic [10:0] cap;
        logic [10:0] exp_frame;
        exp_frame = {1'b1, exp_par, b, 1'b0};
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(b, inject, ok);
        dev_frame(1'b1, 0, cap);
        check_val("frame", cap, exp_frame);
        check_val("parity", cap[9], exp_par);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("done_seen", seen, 1);
        check_val("ready_during_done", tx_ready, 0);
        @(negedge clk);
        check_val("ready_after_done", tx_ready, 1);
        check_val("busy_after_done", busy, 0);
        repeat (200) @(negedge clk);
        check_val("done_count", done_cnt - d0, 1);
        check_val("err_count_ok", err_cnt - e0, 0);
        check_val("idle_keyclk_oe", keyclk_oe, 0);
        $display("tx %02h: frame=%b done=%0d", b, cap, done_cnt - d0);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          n;
        int          d0;
        int          e0;
        logic [10:0] cap;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_keyclk_oe", keyclk_oe, 0);
        check_val("rst_keyinput_oe", keyinput_oe, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_tx_ready", tx_ready, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("post_rst_ready", tx_ready, 1);

        // Normal transfers with hand-computed odd parity
        send_ok(8'hED, 1'b1, 1'b0);
        send_ok(8'hF4, 1'b0, 1'b0);
        send_ok(8'h00, 1'b1, 1'b0);

        // Device never acknowledges
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hF4, 1'b0, ok);
        dev_frame(1'b0, 0, cap);
        repeat (5) @(negedge clk);
        check_val("noack_err_count", err_cnt - e0, 1);
        check_val("noack_done_count", done_cnt - d0, 0);
        check_val("noack_keyclk_oe", keyclk_oe, 0);
        check_val("noack_keyinput_oe", keyinput_oe, 0);
        check_val("noack_idle", tx_ready, 1);
        $display("tx f4 noack: err=%0d done=%0d", err_cnt - e0, done_cnt - d0);

        // Device never clocks: err exactly TMO cycles after START entry
        e0 = err_cnt;
        start_tx(8'hED, 1'b0, ok);
        n = 1;
        while (n <= TMO + 50) begin
            if (err) break;
            @(negedge clk);
            n++;
        end
        check_val("timeout_cycles", n, TMO);
        repeat (3) @(negedge clk);
        check_val("timeout_err_count", err_cnt - e0, 1);
        check_val("timeout_keyinput_oe", keyinput_oe, 0);
        check_val("timeout_idle", tx_ready, 1);
        $display("tx ed timeout: err after %0d cycles", n);

        // Reset during data bit 4 (d4 of 0xED is 0, so the host is pulling low)
        start_tx(8'hED, 1'b0, ok);
        dev_frame(1'b1, 5, cap);
        check_val("bit4_keyinput_oe", keyinput_oe, 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst_keyclk_oe", keyclk_oe, 0);
        check_val("midrst_keyinput_oe", keyinput_oe, 0);
        check_val("midrst_busy", busy, 0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        $display("tx ed aborted by reset at bit 4");
        send_ok(8'hF4, 1'b0, 1'b0);

        // Request while busy is ignored
        send_ok(8'hED, 1'b1, 1'b1);
        check_val("no_second_tx", busy, 0);

        check_val("done_err_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
